// File: rtl/prog_readback.sv
// Program-memory readback: fetches bytes from program RAM and streams them out as 8N1 UART frames.
// Optional READBACK_CHECKSUM_EN appends a modulo-256 sum of the sent bytes as a final frame.
module prog_readback #(
    parameter int MEM_SIZE   = 32767,
    parameter int BAUD_CYCLE = 868,
    localparam int INSTRW    = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              rstB,
    input  logic              start,
    input  logic [INSTRW-1:0] startAddr,
    input  logic [INSTRW:0]   length,
    input  logic              abort,
    output logic [INSTRW-1:0] memAddr,
    input  logic [31:0]       memData,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int BW = $clog2(BAUD_CYCLE + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, SEND,
`ifdef READBACK_CHECKSUM_EN
        CKSUM,
`endif
        DONE
    } stateT;

    stateT             state, nextState;
    logic [INSTRW-1:0] curAddr, nextAddr;
    logic [INSTRW:0]   remaining;
    logic [31:0]       wordReg;
    logic [7:0]        shiftReg, loadByte;
    logic [3:0]        bitCnt;
    logic [BW-1:0]     baudCnt;
    logic              txReg, loadNow, dataLoad;
    logic              sending, baudEnd, frameEnd, lastByte, wordCross;
`ifdef READBACK_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    assign tx   = txReg;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef READBACK_CHECKSUM_EN
    assign sending = (state == SEND) || (state == CKSUM);
`else
    assign sending = (state == SEND);
`endif
    assign baudEnd   = (baudCnt == BW'(BAUD_CYCLE - 1));
    assign frameEnd  = sending && baudEnd && (bitCnt == 4'd9);
    assign lastByte  = (remaining == (INSTRW+1)'(1));
    assign nextAddr  = curAddr + INSTRW'(1);
    assign wordCross = (nextAddr[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) state <= IDLE;
        else       state <= nextState;
    end

    // loadNow starts a new frame (start bit) on the next cycle; dataLoad marks it as a memory byte
    always_comb begin
        nextState = state;
        loadNow   = 1'b0;
        dataLoad  = 1'b0;
        loadByte  = wordReg[{nextAddr[1:0], 3'b000} +: 8];
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
`ifdef READBACK_CHECKSUM_EN
                        nextState = CKSUM;
                        loadNow   = 1'b1;
                        loadByte  = 8'h00;
`else
                        nextState = DONE;
`endif
                    end else begin
                        nextState = FETCH;
                    end
                end
            end
            FETCH: nextState = LOAD;
            LOAD: begin
                nextState = SEND;
                loadNow   = 1'b1;
                dataLoad  = 1'b1;
                loadByte  = memData[{curAddr[1:0], 3'b000} +: 8];
            end
            SEND: begin
                if (frameEnd) begin
                    if (lastByte) begin
`ifdef READBACK_CHECKSUM_EN
                        nextState = CKSUM;
                        loadNow   = 1'b1;
                        loadByte  = sum;
`else
                        nextState = DONE;
`endif
                    end else if (wordCross) begin
                        nextState = FETCH;
                    end else begin
                        loadNow  = 1'b1;
                        dataLoad = 1'b1;
                    end
                end
            end
`ifdef READBACK_CHECKSUM_EN
            CKSUM: if (frameEnd) nextState = DONE;
`endif
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (abort && state != IDLE) begin
            nextState = IDLE;
            loadNow   = 1'b0;
            dataLoad  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            curAddr   <= '0;
            remaining <= '0;
            memAddr   <= '0;
            wordReg   <= '0;
            shiftReg  <= '0;
            bitCnt    <= '0;
            baudCnt   <= '0;
            txReg     <= 1'b1;
`ifdef READBACK_CHECKSUM_EN
            sum       <= '0;
`endif
        end else if (abort && state != IDLE) begin
            txReg   <= 1'b1;
            bitCnt  <= '0;
            baudCnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                curAddr   <= startAddr;
                remaining <= length;
                memAddr   <= {startAddr[INSTRW-1:2], 2'b00};
`ifdef READBACK_CHECKSUM_EN
                sum       <= '0;
`endif
            end
            if (state == LOAD) wordReg <= memData;
            if (frameEnd) begin
                txReg   <= 1'b1;
                baudCnt <= '0;
                if (state == SEND) begin
                    curAddr   <= nextAddr;
                    remaining <= remaining - (INSTRW+1)'(1);
                    // only move the RAM address when another word is actually needed
                    if (wordCross && !lastByte) memAddr <= {nextAddr[INSTRW-1:2], 2'b00};
                end
            end else if (sending) begin
                if (baudEnd) begin
                    baudCnt  <= '0;
                    bitCnt   <= bitCnt + 4'd1;
                    txReg    <= (bitCnt == 4'd8) ? 1'b1 : shiftReg[0];
                    shiftReg <= {1'b0, shiftReg[7:1]};
                end else begin
                    baudCnt <= baudCnt + BW'(1);
                end
            end
            if (loadNow) begin
                txReg    <= 1'b0;
                shiftReg <= loadByte;
                bitCnt   <= '0;
                baudCnt  <= '0;
`ifdef READBACK_CHECKSUM_EN
                if (dataLoad) sum <= sum + loadByte;
`endif
            end
        end
    end
endmodule

// File: tb/tb_prog_readback.sv
// Directed bench for prog_readback: decodes UART frames bit-exactly and checks fetch addresses.
module tb_prog_readback;
    localparam int B = 4;
    localparam int MS = 64;

    logic clk = 1'b0;
    logic rstB, start, abort;
    logic [5:0] startAddr, memAddr;
    logic [6:0] length;
    logic [31:0] memData;
    logic tx, busy, done;

    logic [31:0] mem [0:15];
    logic [5:0] addrLog[$];
    int total = 0, bad = 0, doneCnt = 0;
    logic [7:0] benchSum;

    prog_readback #(.MEM_SIZE(MS), .BAUD_CYCLE(B)) dut (
        .clk(clk), .rstB(rstB), .start(start), .startAddr(startAddr), .length(length),
        .abort(abort), .memAddr(memAddr), .memData(memData), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) memData <= mem[memAddr[5:2]];
    always @(negedge clk) begin
        if (done) doneCnt++;
        if (busy && (addrLog.size() == 0 || addrLog[addrLog.size()-1] != memAddr)) addrLog.push_back(memAddr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the frame's last sample.
    task automatic rxFrame(output logic [7:0] d, output bit good, output int gap);
        logic [9:0] bits;
        logic s;
        good = 1'b1;
        gap = 0;
        bits = '0;
        while (tx !== 1'b0 && gap < 300) begin @(negedge clk); gap++; end
        if (gap >= 300) good = 1'b0;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < B; j++) begin
                s = tx;
                if (j == 0) bits[i] = s;
                else if (s !== bits[i]) good = 1'b0;
                @(negedge clk);
            end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) good = 1'b0;
        d = bits[8:1];
    endtask

    task automatic rxCheck(input string tag, input logic [7:0] exp, input bit chkGap);
        logic [7:0] d;
        bit good;
        int gap;
        rxFrame(d, good, gap);
        check(tag, d, exp);
        check({tag, " fmt"}, good, 1);
        if (chkGap) check({tag, " gap"}, gap <= 3, 1);
        benchSum = benchSum + exp;
    endtask

    task automatic tail(input string tag);
`ifdef READBACK_CHECKSUM_EN
        rxCheck({tag, " cksum"}, benchSum, 1'b1);
`endif
        repeat (5) @(negedge clk);
        #1;
        check({tag, " done"}, doneCnt, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " tx"}, tx, 1);
    endtask

    task automatic doStart(input logic [5:0] a, input logic [6:0] l, input logic ab);
        startAddr = a; length = l; abort = ab; start = 1'b1;
        doneCnt = 0; benchSum = 8'h00;
        addrLog.delete();
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h44332211;
        mem[1] = 32'h88776655;
        mem[2] = 32'h000002FF;
        mem[15] = 32'hA5000000;
        rstB = 1'b0; start = 1'b0; abort = 1'b0; startAddr = '0; length = '0; benchSum = 8'h00;
        repeat (3) @(negedge clk);
        check("rst tx", tx, 1);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst memAddr", memAddr, 0);
        rstB = 1'b1;
        @(negedge clk);

        // aligned word dump
        doStart(6'd0, 7'd4, 1'b0);
        rxCheck("w0 b0", 8'h11, 1'b0);
        rxCheck("w0 b1", 8'h22, 1'b1);
        rxCheck("w0 b2", 8'h33, 1'b1);
        rxCheck("w0 b3", 8'h44, 1'b1);
        tail("w0");
        check("w0 nfetch", addrLog.size(), 1);
        check("w0 fetch0", addrLog[0], 0);

        // unaligned start crossing a word
        doStart(6'd2, 7'd3, 1'b0);
        rxCheck("un b0", 8'h33, 1'b0);
        rxCheck("un b1", 8'h44, 1'b1);
        rxCheck("un b2", 8'h55, 1'b1);
        tail("un");
        check("un nfetch", addrLog.size(), 2);
        check("un fetch0", addrLog[0], 0);
        check("un fetch1", addrLog[1], 4);

        // zero length
        doStart(6'd4, 7'd0, 1'b0);
`ifdef READBACK_CHECKSUM_EN
        rxCheck("z cksum", 8'h00, 1'b1);
        tail("z");
`else
        check("z busy", busy, 1);
        check("z done", done, 1);
        check("z tx", tx, 1);
        @(negedge clk);
        check("z busy off", busy, 0);
        check("z done off", done, 0);
        #1;
        check("z donecnt", doneCnt, 1);
`endif

`ifdef READBACK_CHECKSUM_EN
        doStart(6'd8, 7'd2, 1'b0);
        rxCheck("ck b0", 8'hFF, 1'b0);
        rxCheck("ck b1", 8'h02, 1'b1);
        check("ck model", benchSum, 8'h01);
        tail("ck");
`endif

        // abort in frame position 5 of the second frame (data bit 4 of 0x22 = 0)
        doStart(6'd0, 7'd4, 1'b0);
        rxCheck("ab b0", 8'h11, 1'b0);
        repeat (5 * B) @(negedge clk);
        check("ab pre tx", tx, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab tx", tx, 1);
        check("ab busy", busy, 0);
        repeat (10) @(negedge clk);
        #1;
        check("ab nodone", doneCnt, 0);
        check("ab idle tx", tx, 1);
        @(negedge clk);

        // restart with abort also high in IDLE: start wins
        doStart(6'd0, 7'd4, 1'b1);
        check("rs busy", busy, 1);
        rxCheck("rs b0", 8'h11, 1'b0);
        rxCheck("rs b1", 8'h22, 1'b1);
        rxCheck("rs b2", 8'h33, 1'b1);
        rxCheck("rs b3", 8'h44, 1'b1);
        tail("rs");

        // asynchronous reset during a start bit
        doStart(6'd0, 7'd4, 1'b0);
        n = 0;
        while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        check("ar txlow", tx, 0);
        #2 rstB = 1'b0;
        #1;
        check("ar tx", tx, 1);
        check("ar busy", busy, 0);
        check("ar memAddr", memAddr, 0);
        @(negedge clk);
        rstB = 1'b1;
        n = 0;
        repeat (30) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0) n++; end
        check("ar quiet", n, 0);
        check("ar nodone", doneCnt, 0);

        // address wrap from the last byte to address 0
        doStart(6'd63, 7'd2, 1'b0);
        rxCheck("wr b0", 8'hA5, 1'b0);
        rxCheck("wr b1", 8'h11, 1'b1);
        tail("wr");
        check("wr nfetch", addrLog.size(), 2);
        check("wr fetch0", addrLog[0], 60);
        check("wr fetch1", addrLog[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
